// File: rtl/tdm_mux_reg.sv
// Registered N-input mux for the one-way ring, time-division scheduled per domain.
// Each input port is a security domain with its own one-entry buffer. A slot of
// p_slot_cycles cycles rotates through the domains regardless of traffic, so one
// domain's valids or backpressure can never shift when another domain is served.
module tdm_mux_reg #(
    parameter int unsigned p_nbits       = 32,
    parameter int unsigned p_nports      = 4,
    parameter int unsigned p_slot_cycles = 4,
    localparam int unsigned c_dbits      = (p_nports > 1) ? $clog2(p_nports) : 1,
    localparam int unsigned c_cbits      = (p_slot_cycles > 1) ? $clog2(p_slot_cycles) : 1
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [p_nports-1:0]           in_val_i,
    input  logic [p_nports*p_nbits-1:0]   in_msg_i,
    output logic [p_nports-1:0]           in_rdy_o,
    output logic                          out_val_o,
    output logic [p_nbits-1:0]            out_msg_o,
    input  logic                          out_rdy_i,
    output logic [c_dbits-1:0]            out_domain_o,
    output logic                          slot_start_o
);

    localparam logic [c_dbits-1:0] SlotMax = c_dbits'(p_nports - 1);
    localparam logic [c_cbits-1:0] CntMax  = c_cbits'(p_slot_cycles - 1);

    logic [c_dbits-1:0] slot_q, slot_d;
    logic [c_cbits-1:0] cnt_q, cnt_d;
    logic [p_nports-1:0] buf_val_q, buf_val_d;
    logic [p_nbits-1:0]  buf_msg_q [p_nports];
    logic [p_nbits-1:0]  buf_msg_d [p_nports];
    logic                deq;

    // Slot scheduler: free-running, never looks at valids or out_rdy.
    always_comb begin
        cnt_d  = cnt_q + c_cbits'(1);
        slot_d = slot_q;
        if (cnt_q == CntMax) begin
            cnt_d  = '0;
            slot_d = (slot_q == SlotMax) ? '0 : slot_q + c_dbits'(1);
        end
    end

    // Outputs come only from the current slot's buffer; an empty buffer shows zero.
    always_comb begin
        out_domain_o = slot_q;
        slot_start_o = (cnt_q == '0);
        out_val_o    = buf_val_q[slot_q];
        out_msg_o    = buf_val_q[slot_q] ? buf_msg_q[slot_q] : '0;
        deq          = buf_val_q[slot_q] && out_rdy_i;
        for (int i = 0; i < int'(p_nports); i++) begin
            // Ready depends only on slot, own buffer and out_rdy, never on any in_val.
            in_rdy_o[i] = (slot_q == c_dbits'(i)) && (!buf_val_q[i] || out_rdy_i);
        end
    end

    // Buffer next state: dequeue first, then a same-cycle enqueue overrides it.
    always_comb begin
        buf_val_d = buf_val_q;
        for (int i = 0; i < int'(p_nports); i++) begin
            buf_msg_d[i] = buf_msg_q[i];
            if (deq && (slot_q == c_dbits'(i))) begin
                buf_val_d[i] = 1'b0;
            end
            if (in_val_i[i] && in_rdy_o[i]) begin
                buf_val_d[i] = 1'b1;
                buf_msg_d[i] = in_msg_i[i*p_nbits +: p_nbits];
            end
        end
    end

    // State registers with synchronous reset; reset discards all buffered traffic.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            slot_q    <= '0;
            cnt_q     <= '0;
            buf_val_q <= '0;
            for (int i = 0; i < int'(p_nports); i++) begin
                buf_msg_q[i] <= '0;
            end
        end else begin
            slot_q    <= slot_d;
            cnt_q     <= cnt_d;
            buf_val_q <= buf_val_d;
            for (int i = 0; i < int'(p_nports); i++) begin
                buf_msg_q[i] <= buf_msg_d[i];
            end
        end
    end

endmodule

// File: doc/tdm_mux_reg.md
Name: tdm_mux_reg

Overview:
- Parametrised, registered N-input mux for the one-way ring network, with timing-channel protection.
- Time-division schedules p_nports security domains. Each input port owns one domain, and each domain gets a fixed slot of p_slot_cycles cycles, in rotation.
- Uses a valid/ready handshake on both sides. Each domain has its own one-entry output buffer, so no domain's traffic or backpressure can change when another domain is served.
- Replaces fixed combinational muxes at ring injection points.

Parameters:
- p_nbits, 32, message width in bits.
- p_nports, 4, number of input ports/domains (≥2).
- p_slot_cycles, 4, cycles per domain slot (≥1).
- c_dbits (local), max(1, clog2(p_nports)), domain index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_val  in  p_nports  per-port valid.
- in_msg  in  p_nports*p_nbits  port i occupies bits [i*p_nbits +: p_nbits].
- in_rdy  out  p_nports  per-port ready.
- out_val  out  1  output valid.
- out_msg  out  p_nbits  output message.
- out_rdy  in  1  downstream ready.
- out_domain  out  c_dbits  domain of the current slot; this is the label of out_msg.
- slot_start  out  1  high on the first cycle of every slot.

Behaviour:
- State:
  - slot register, 0..p_nports-1.
  - cycle counter cnt, 0..p_slot_cycles-1.
  - per-port buffers buf_val[i] and buf_msg[i].
- Reset (synchronous, while reset=1 at the edge):
  - slot=0, cnt=0, all buf_val=0, all buf_msg=0.
  - Outputs in the cycle after reset: out_val=0, out_msg=0, in_rdy=0 except in_rdy[0]=1, out_domain=0, slot_start=1.
  - Reset mid-operation discards all buffered messages and restarts at slot 0, cnt 0.
- Scheduler:
  - Each cycle: if cnt==p_slot_cycles-1 then cnt←0 and slot←(slot==p_nports-1 ? 0 : slot+1); else cnt←cnt+1.
  - Advances unconditionally, independent of all valids and out_rdy.
  - slot_start = (cnt==0). With p_slot_cycles=1, slot_start is constantly 1 and the slot changes every cycle.
- Outputs (combinational from state):
  - out_domain = slot.
  - out_val = buf_val[slot].
  - out_msg = buf_msg[slot] when buf_val[slot], else 0 (no stale data from other domains).
- Input acceptance:
  - in_rdy[i] = (slot==i) && (!buf_val[i] || out_rdy).
  - Ports outside their slot always see in_rdy=0.
  - in_rdy must not depend on in_val of any port.
- Dequeue: when out_val && out_rdy, buf_val[slot]←0, unless an enqueue on the same port happens in the same cycle.
- Enqueue: when in_val[i] && in_rdy[i], buf_msg[i]←in_msg[i] and buf_val[i]←1.
- Simultaneous dequeue and enqueue on the same port: buffer holds the new message and buf_val stays 1. This gives full throughput of one message per cycle within a slot.
- Latency: a message accepted at edge t appears on out_msg at cycle t+1, provided slot still equals i. Otherwise it waits in buf[i] until domain i's next slot.
- Slot boundary with an undelivered buffer:
  - The message stays in buf[i] and out_val drops as the slot changes.
  - It is presented again at the start of domain i's next slot.
  - Other domains are unaffected.
- Messages per port are never dropped, duplicated or reordered. in_msg is sampled only on handshake.

Test Plan (p_nbits=8, p_nports=4, p_slot_cycles=4):
1. Reset and idle:
   - Stimulus: hold reset 2 cycles, then release with all in_val=0.
   - Required: out_val=0, out_msg=0; out_domain sequence 0,0,0,0,1,1,1,1,2,…,3,3,3,3,0; slot_start high every 4th cycle starting at the first post-reset cycle; in_rdy one-hot tracking out_domain.
2. Streaming in own slot:
   - Stimulus: in_val[0]=1 continuously with msgs 0x11,0x22,0x33; out_rdy=1.
   - Required: accepted on cnt 0,1,2; out_msg 0x11,0x22,0x33 on cnt 1,2,3.
3. Backpressure across a boundary:
   - Stimulus: port1 sends 0xA5 at cnt=3 of slot 1; out_rdy=0 for the remainder of that slot.
   - Required: out_val drops at slot 2; port2 traffic (0x5A) is accepted and output normally in slot 2; 0xA5 appears again with out_val=1 at the first cycle of the next slot 1.
4. Non-interference:
   - Stimulus: run the same port2 stimulus twice, once with ports 0,1,3 idle and once with them saturated and out_rdy toggling in their slots.
   - Required: port2 in_rdy and out_val/out_msg traces are cycle-identical in both runs.
5. Full-buffer hold:
   - Stimulus: buf[3] full with 0x7E, out_rdy=0, in_val[3]=1 carrying 0x99.
   - Required: in_rdy[3]=0 and 0x7E is held. Then raise out_rdy=1: 0x7E is dequeued and 0x99 is enqueued in the same cycle, and 0x99 is output next cycle.
6. Reset mid-operation:
   - Stimulus: buffers 0 and 2 full; assert reset for 1 cycle.
   - Required: next cycle all buffers empty, out_val=0, slot=0, slot_start=1; the discarded messages never appear on out_msg.
